motor_cmd_dispatch: RTL and testbench

Parametrised UART command dispatcher for the vertical motor CPLD. Sits between the byte-level `async_receiver`/`async_transmitter` pair and an array of `NUM_CH` motor controllers. Assembles 5-byte command frames, buffers them in a per-channel FIFO of depth `DEPTH`, and hands commands to each controller with a valid/ready handshake. Reports per-channel free-space flags back to the host over UART in a round-robin sequence of status bytes.

---
 rtl/motor_pkg.sv | 26 ++
 rtl/cmd_fifo.sv | 64 ++++++
 rtl/motor_cmd_dispatch.sv | 238 +++++++++++++++++++++++
 tb/tb_motor_cmd_dispatch.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/motor_pkg.sv
// motor_pkg
// Shared definitions for the motor command dispatcher: frame and group
// sizes, the receive and status FSM state types, and the group-count helper.
package motor_pkg;

   localparam int FRAME_BYTES = 5;   // address byte + 4 payload bytes
   localparam int GROUP_SZ    = 5;   // channels reported per status byte

   typedef enum logic [0:0] {
      R_ADDR = 1'b0,
      R_PAY  = 1'b1
   } rx_state_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAITB = 2'd1,
      S_WAITD = 2'd2,
      S_GAP   = 2'd3
   } st_state_t;

   // Number of status groups needed to cover n channels.
   function automatic int num_groups(input int n);
      return (n + GROUP_SZ - 1) / GROUP_SZ;
   endfunction

endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo
// Small register FIFO holding decoded motor commands for one channel.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   push, din  : write request and data (ignored when full)
//   pop        : consume the head entry (ignored when empty)
//   head       : current head entry, meaningful while empty is low
//   full/empty : occupancy flags, derived from the registered count
module cmd_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W-1:0] wr_ptr_q;
   logic [CNT_W-1:0] cnt_q;
   logic             do_push_s;
   logic             do_pop_s;

   assign full      = (cnt_q == CNT_W'(DEPTH));
   assign empty     = (cnt_q == {CNT_W{1'b0}});
   assign do_push_s = push & ~full;
   assign do_pop_s  = pop & ~empty;
   assign head      = mem_q[rd_ptr_q];

   // Storage, pointers (wrap naturally, DEPTH is a power of two) and count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {WIDTH{1'b0}};
         end
         rd_ptr_q <= {PTR_W{1'b0}};
         wr_ptr_q <= {PTR_W{1'b0}};
         cnt_q    <= {CNT_W{1'b0}};
      end else begin
         if (do_push_s) begin
            mem_q[wr_ptr_q] <= din;
            wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
         end
         if (do_pop_s) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         case ({do_push_s, do_pop_s})
            2'b10:   cnt_q <= cnt_q + CNT_W'(1);
            2'b01:   cnt_q <= cnt_q - CNT_W'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/motor_cmd_dispatch.sv
// motor_cmd_dispatch
// UART command dispatcher: assembles 5-byte frames (address, P0..P3) from the
// byte receiver, queues {P3,P2,P1,P0} in a per-channel FIFO, presents FIFO
// heads to the motor controllers, and reports per-channel free space to the
// host as round-robin status bytes {group[2:0], space[4:0]}.
// Ports:
//   CLK, reset          : clock, asynchronous active-high reset
//   rx_ready, rx_data   : receiver data-ready level and byte
//   tx_start, tx_data   : transmitter start pulse and status byte
//   tx_busy             : transmitter busy
//   cmd_valid/cmd_ready : per-channel head valid / pop
//   cmd_div, cmd_steps  : per-channel packed head fields
//   drop_cnt            : saturating count of discarded frames
module motor_cmd_dispatch
   import motor_pkg::*;
#(
   parameter int NUM_CH      = 10,
   parameter int DEPTH       = 2,
   parameter int DIV_W       = 15,
   parameter int STEP_W      = 17,
   parameter int TIMEOUT_CYC = 4800,
   parameter int STATUS_GAP  = 255
) (
   input  logic                     CLK,
   input  logic                     reset,
   input  logic                     rx_ready,
   input  logic [7:0]               rx_data,
   output logic                     tx_start,
   output logic [7:0]               tx_data,
   input  logic                     tx_busy,
   output logic [NUM_CH-1:0]        cmd_valid,
   input  logic [NUM_CH-1:0]        cmd_ready,
   output logic [NUM_CH*DIV_W-1:0]  cmd_div,
   output logic [NUM_CH*STEP_W-1:0] cmd_steps,
   output logic [7:0]               drop_cnt
);

   localparam int NG        = num_groups(NUM_CH);
   localparam int PAD_W     = NG * GROUP_SZ;
   localparam int PAY_BYTES = FRAME_BYTES - 1;
   localparam int TO_W      = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
   localparam int GAP_W     = (STATUS_GAP < 1) ? 1 : $clog2(STATUS_GAP + 1);

   // ---------------- receive side ----------------
   logic            rx_ready_q;
   logic            rx_edge_s;
   rx_state_t       rx_st_q;
   logic [1:0]      idx_q;
   logic [7:0]      addr_q;
   logic [23:0]     pay_q;        // P2,P1,P0 shifted in, newest at the top
   logic [TO_W-1:0] to_cnt_q;
   logic            commit_s;
   logic [31:0]     frame_word_s;
   logic [NUM_CH-1:0] push_s;
   logic            drop_s;
   logic [7:0]      drop_cnt_q;

   logic [NUM_CH-1:0] full_s;
   logic [NUM_CH-1:0] empty_s;
   logic [31:0]       head_s [NUM_CH];

   assign rx_edge_s    = rx_ready & ~rx_ready_q;
   assign commit_s     = (rx_st_q == R_PAY) && rx_edge_s && (idx_q == 2'(PAY_BYTES - 1));
   assign frame_word_s = {rx_data, pay_q};

   // Route a committed frame to its channel; fullness is the pre-pop value.
   always_comb begin
      push_s = {NUM_CH{1'b0}};
      for (int c = 0; c < NUM_CH; c++) begin
         if (commit_s && (addr_q == 8'(c)) && !full_s[c]) begin
            push_s[c] = 1'b1;
         end else begin
            push_s[c] = 1'b0;
         end
      end
   end

   // A commit that wrote nowhere (bad address or full FIFO) is a drop.
   assign drop_s = commit_s & ~(|push_s);

   // Receive FSM: edge detect, address/payload capture, inter-byte timeout.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         rx_ready_q <= 1'b0;
         rx_st_q    <= R_ADDR;
         idx_q      <= 2'd0;
         addr_q     <= 8'd0;
         pay_q      <= 24'd0;
         to_cnt_q   <= {TO_W{1'b0}};
      end else begin
         rx_ready_q <= rx_ready;
         case (rx_st_q)
            R_ADDR: begin
               to_cnt_q <= {TO_W{1'b0}};
               if (rx_edge_s) begin
                  addr_q  <= rx_data;
                  idx_q   <= 2'd0;
                  rx_st_q <= R_PAY;
               end
            end
            R_PAY: begin
               if (rx_edge_s) begin
                  to_cnt_q <= {TO_W{1'b0}};
                  pay_q    <= {rx_data, pay_q[23:8]};
                  if (idx_q == 2'(PAY_BYTES - 1)) begin
                     idx_q   <= 2'd0;
                     rx_st_q <= R_ADDR;
                  end else begin
                     idx_q <= idx_q + 2'd1;
                  end
               end else if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
                  // Partial frame abandoned silently; not a drop.
                  to_cnt_q <= {TO_W{1'b0}};
                  idx_q    <= 2'd0;
                  rx_st_q  <= R_ADDR;
               end else begin
                  to_cnt_q <= to_cnt_q + TO_W'(1);
               end
            end
            default: begin
               rx_st_q <= R_ADDR;
            end
         endcase
      end
   end

   // Saturating drop counter.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         drop_cnt_q <= 8'd0;
      end else if (drop_s && (drop_cnt_q != 8'hFF)) begin
         drop_cnt_q <= drop_cnt_q + 8'd1;
      end
   end

   assign drop_cnt = drop_cnt_q;

   // ---------------- per-channel FIFOs ----------------
   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      cmd_fifo #(
         .WIDTH(32),
         .DEPTH(DEPTH)
      ) u_fifo (
         .clk  (CLK),
         .rst  (reset),
         .push (push_s[c]),
         .pop  (cmd_ready[c]),
         .din  (frame_word_s),
         .head (head_s[c]),
         .full (full_s[c]),
         .empty(empty_s[c])
      );
      assign cmd_valid[c]                    = ~empty_s[c];
      assign cmd_div[c*DIV_W +: DIV_W]       = head_s[c][DIV_W-1:0];
      assign cmd_steps[c*STEP_W +: STEP_W]   = head_s[c][31:DIV_W];
   end

   // ---------------- status transmit side ----------------
   st_state_t        st_q;
   logic [2:0]       g_q;
   logic [1:0]       wb_cnt_q;
   logic [GAP_W-1:0] gap_q;
   logic             tx_start_q;
   logic [7:0]       tx_data_q;
   logic [PAD_W-1:0] space_pad_s;
   logic             any_space_s;
   logic [4:0]       grp_bits_s;
   logic [7:0]       status_byte_s;

   // Space flags padded to whole groups; missing channels read as 0.
   always_comb begin
      space_pad_s = {PAD_W{1'b0}};
      for (int c = 0; c < NUM_CH; c++) begin
         space_pad_s[c] = ~full_s[c];
      end
   end

   assign any_space_s   = |space_pad_s;
   assign grp_bits_s    = space_pad_s[int'(g_q)*GROUP_SZ +: GROUP_SZ];
   assign status_byte_s = {g_q, grp_bits_s};

   // Status FSM: send a byte, wait for the transmitter, then idle a gap.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         st_q       <= S_IDLE;
         g_q        <= 3'd0;
         wb_cnt_q   <= 2'd0;
         gap_q      <= {GAP_W{1'b0}};
         tx_start_q <= 1'b0;
         tx_data_q  <= 8'd0;
      end else begin
         tx_start_q <= 1'b0;
         case (st_q)
            S_IDLE: begin
               if (any_space_s && !tx_busy) begin
                  tx_data_q  <= status_byte_s;
                  tx_start_q <= 1'b1;
                  wb_cnt_q   <= 2'd0;
                  st_q       <= S_WAITB;
               end
            end
            S_WAITB: begin
               // Do not hang if the transmitter never reports busy.
               if (tx_busy || (wb_cnt_q == 2'd3)) begin
                  st_q <= S_WAITD;
               end else begin
                  wb_cnt_q <= wb_cnt_q + 2'd1;
               end
            end
            S_WAITD: begin
               if (!tx_busy) begin
                  gap_q <= GAP_W'(STATUS_GAP);
                  st_q  <= S_GAP;
               end
            end
            S_GAP: begin
               if (gap_q == {GAP_W{1'b0}}) begin
                  if (g_q == 3'(NG - 1)) begin
                     g_q <= 3'd0;
                  end else begin
                     g_q <= g_q + 3'd1;
                  end
                  st_q <= S_IDLE;
               end else begin
                  gap_q <= gap_q - GAP_W'(1);
               end
            end
            default: begin
               st_q <= S_IDLE;
            end
         endcase
      end
   end

   assign tx_start = tx_start_q;
   assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_motor_cmd_dispatch.sv
// tb_motor_cmd_dispatch
// Directed, table-driven bench for motor_cmd_dispatch with a simple
// transmitter model that holds tx_busy for a fixed time after each start.
module tb_motor_cmd_dispatch;

   localparam int NUM_CH      = 10;
   localparam int DEPTH       = 2;
   localparam int DIV_W       = 15;
   localparam int STEP_W      = 17;
   localparam int TIMEOUT_CYC = 4800;
   localparam int STATUS_GAP  = 255;

   logic                     CLK = 1'b0;
   logic                     reset = 1'b1;
   logic                     rx_ready = 1'b0;
   logic [7:0]               rx_data = 8'd0;
   logic                     tx_start;
   logic [7:0]               tx_data;
   logic                     tx_busy = 1'b0;
   logic [NUM_CH-1:0]        cmd_valid;
   logic [NUM_CH-1:0]        cmd_ready = '0;
   logic [NUM_CH*DIV_W-1:0]  cmd_div;
   logic [NUM_CH*STEP_W-1:0] cmd_steps;
   logic [7:0]               drop_cnt;

   motor_cmd_dispatch #(
      .NUM_CH(NUM_CH), .DEPTH(DEPTH), .DIV_W(DIV_W), .STEP_W(STEP_W),
      .TIMEOUT_CYC(TIMEOUT_CYC), .STATUS_GAP(STATUS_GAP)
   ) dut (
      .CLK(CLK), .reset(reset), .rx_ready(rx_ready), .rx_data(rx_data),
      .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_div(cmd_div),
      .cmd_steps(cmd_steps), .drop_cnt(drop_cnt)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int busy_cnt = 0;
   logic [7:0] log_b [$];
   int         log_t [$];

   always @(posedge CLK) cyc <= cyc + 1;

   // Transmitter model: busy for 10 cycles after each start pulse.
   always @(posedge CLK) begin
      if (reset) begin
         busy_cnt <= 0;
         tx_busy  <= 1'b0;
      end else if (tx_start) begin
         busy_cnt <= 10;
         tx_busy  <= 1'b1;
      end else if (busy_cnt > 1) begin
         busy_cnt <= busy_cnt - 1;
      end else begin
         busy_cnt <= 0;
         tx_busy  <= 1'b0;
      end
   end

   // Record every status byte with its start cycle.
   always @(negedge CLK) begin
      if (tx_start) begin
         log_b.push_back(tx_data);
         log_t.push_back(cyc);
      end
   end

   typedef struct {
      logic [7:0]        addr;
      logic [31:0]       word;
      int                chk_ch;
      logic              exp_valid;
      logic [DIV_W-1:0]  exp_div;
      logic [STEP_W-1:0] exp_steps;
      logic [7:0]        exp_drop;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [DIV_W-1:0] div_of(input int c);
      return cmd_div[c*DIV_W +: DIV_W];
   endfunction

   function automatic logic [STEP_W-1:0] steps_of(input int c);
      return cmd_steps[c*STEP_W +: STEP_W];
   endfunction

   // rdy is applied for the single clock that captures this byte.
   task automatic send_byte(input logic [7:0] b, input logic [NUM_CH-1:0] rdy);
      @(negedge CLK);
      rx_data   = b;
      rx_ready  = 1'b1;
      cmd_ready = rdy;
      @(negedge CLK);
      cmd_ready = '0;
      @(negedge CLK);
      rx_ready = 1'b0;
      @(negedge CLK);
   endtask

   task automatic send_frame(input logic [7:0] addr, input logic [31:0] w,
                             input logic [NUM_CH-1:0] rdy_p3);
      send_byte(addr, '0);
      send_byte(w[7:0], '0);
      send_byte(w[15:8], '0);
      send_byte(w[23:16], '0);
      send_byte(w[31:24], rdy_p3);
   endtask

   task automatic pop_ch(input int c);
      @(negedge CLK);
      cmd_ready    = '0;
      cmd_ready[c] = 1'b1;
      @(negedge CLK);
      cmd_ready = '0;
   endtask

   initial begin
      int start_idx;
      int wait_n;

      vecs[0] = '{8'h03, 32'h8000_1234, 3, 1'b1, 15'h1234, 17'h10000, 8'd0};
      vecs[1] = '{8'h07, 32'hFFFF_FFFF, 7, 1'b1, 15'h7FFF, 17'h1FFFF, 8'd0};
      vecs[2] = '{8'h09, 32'h0000_8000, 9, 1'b1, 15'h0000, 17'h00001, 8'd0};
      vecs[3] = '{8'h0C, 32'hCAFE_F00D, 9, 1'b1, 15'h0000, 17'h00001, 8'd1};
      vecs[4] = '{8'h0A, 32'h0BAD_BEEF, 0, 1'b0, 15'h0000, 17'h00000, 8'd2};
      vecs[5] = '{8'h00, 32'h0001_7FFF, 0, 1'b1, 15'h7FFF, 17'h00002, 8'd2};
      vecs[6] = '{8'h00, 32'h1234_5678, 0, 1'b1, 15'h7FFF, 17'h00002, 8'd2};
      vecs[7] = '{8'h00, 32'hDEAD_BEEF, 0, 1'b1, 15'h7FFF, 17'h00002, 8'd3};

      // Reset state while reset is held.
      repeat (3) @(negedge CLK);
      check("rst_tx_start", 32'(tx_start), 32'd0);
      check("rst_tx_data", 32'(tx_data), 32'd0);
      check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
      check("rst_cmd_div0", 32'(div_of(0)), 32'd0);
      check("rst_cmd_steps0", 32'(steps_of(0)), 32'd0);
      check("rst_drop_cnt", 32'(drop_cnt), 32'd0);

      // First status byte in cycle 1: group 0, all five channels free.
      reset = 1'b0;
      @(negedge CLK);
      check("first_tx_start", 32'(tx_start), 32'd1);
      check("first_tx_data", 32'(tx_data), 32'h1F);
      @(negedge CLK);
      check("tx_start_width", 32'(tx_start), 32'd0);

      // Table: commit, bad addresses, boundary channels, overflow.
      for (int i = 0; i < 8; i++) begin
         send_frame(vecs[i].addr, vecs[i].word, '0);
         check($sformatf("v%0d_valid", i), 32'(cmd_valid[vecs[i].chk_ch]), 32'(vecs[i].exp_valid));
         check($sformatf("v%0d_div", i), 32'(div_of(vecs[i].chk_ch)), 32'(vecs[i].exp_div));
         check($sformatf("v%0d_steps", i), 32'(steps_of(vecs[i].chk_ch)), 32'(vecs[i].exp_steps));
         check($sformatf("v%0d_drop", i), 32'(drop_cnt), 32'(vecs[i].exp_drop));
      end

      // Pop ch0: second entry surfaces, then channel empties.
      pop_ch(0);
      check("pop1_valid", 32'(cmd_valid[0]), 32'd1);
      check("pop1_div", 32'(div_of(0)), 32'h5678);
      check("pop1_steps", 32'(steps_of(0)), 32'h2468);
      pop_ch(0);
      check("pop2_valid", 32'(cmd_valid[0]), 32'd0);

      // Push and pop on the same commit cycle keep occupancy at one.
      send_frame(8'h02, 32'h0000_0011, '0);
      check("pp_first_div", 32'(div_of(2)), 32'h11);
      send_frame(8'h02, 32'h0000_0022, 10'b00_0000_0100);
      check("pp_valid", 32'(cmd_valid[2]), 32'd1);
      check("pp_div", 32'(div_of(2)), 32'h22);
      pop_ch(2);
      check("pp_after_pop", 32'(cmd_valid[2]), 32'd0);

      // Inter-byte timeout discards a partial frame without counting it.
      send_byte(8'h04, '0);
      send_byte(8'hAA, '0);
      send_byte(8'hBB, '0);
      repeat (TIMEOUT_CYC + 1) @(negedge CLK);
      send_frame(8'h05, 32'h0000_0055, '0);
      check("to_ch5_valid", 32'(cmd_valid[5]), 32'd1);
      check("to_ch5_div", 32'(div_of(5)), 32'h55);
      check("to_ch4_valid", 32'(cmd_valid[4]), 32'd0);
      check("to_drop", 32'(drop_cnt), 32'd3);

      // Fill channels 0..4 so group 0 reports no space.
      send_frame(8'h00, 32'h1, '0); send_frame(8'h00, 32'h2, '0);
      send_frame(8'h01, 32'h3, '0); send_frame(8'h01, 32'h4, '0);
      send_frame(8'h02, 32'h5, '0); send_frame(8'h02, 32'h6, '0);
      send_frame(8'h03, 32'h7, '0);
      send_frame(8'h04, 32'h8, '0); send_frame(8'h04, 32'h9, '0);
      check("fill_valid", 32'(cmd_valid[4:0]), 32'h1F);
      check("fill_drop", 32'(drop_cnt), 32'd3);

      @(negedge CLK);
      start_idx = log_b.size();
      wait_n = 0;
      while (wait_n < 4000 && (log_b.size() - start_idx) < 4) begin
         @(negedge CLK);
         wait_n++;
      end
      check("status_count_ok", 32'((log_b.size() - start_idx) >= 4), 32'd1);
      if ((log_b.size() - start_idx) >= 4) begin
         check("status_first_legal",
               32'((log_b[start_idx] == 8'h00) || (log_b[start_idx] == 8'h3F)), 32'd1);
         for (int i = start_idx; i < start_idx + 3; i++) begin
            check("status_alternate", 32'(log_b[i+1]),
                  (log_b[i] == 8'h00) ? 32'h3F : 32'h00);
            check("status_gap_ok", 32'((log_t[i+1] - log_t[i]) >= STATUS_GAP), 32'd1);
         end
      end

      // Drop counter saturation.
      for (int i = 0; i < 251; i++) begin
         send_frame(8'hFF, 32'h0, '0);
      end
      check("drop_254", 32'(drop_cnt), 32'd254);
      send_frame(8'hFF, 32'h0, '0);
      send_frame(8'hFF, 32'h0, '0);
      check("drop_sat", 32'(drop_cnt), 32'd255);

      // Reset mid-frame returns everything to idle.
      send_byte(8'h06, '0);
      send_byte(8'h11, '0);
      reset = 1'b1;
      @(negedge CLK);
      check("mid_rst_valid", 32'(cmd_valid), 32'd0);
      check("mid_rst_drop", 32'(drop_cnt), 32'd0);
      reset = 1'b0;
      send_frame(8'h06, 32'h0000_0066, '0);
      check("post_rst_valid", 32'(cmd_valid), 32'h040);
      check("post_rst_div", 32'(div_of(6)), 32'h66);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
